// File: rtl/jk_input_conditioner_if.sv
// Button bus between the board pins and the JK flip-flop stage:
// raw buttons in, debounced level and edge pulses out.
interface jk_input_conditioner_if #(
    parameter int N_CH = 2
);
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_rise;
    logic [N_CH-1:0] btn_fall;

    modport master (output btn_raw, input btn_level, input btn_rise, input btn_fall);
    modport slave  (input btn_raw, output btn_level, output btn_rise, output btn_fall);
endinterface

// File: rtl/jk_input_conditioner.sv
// Per-channel 2-FF synchroniser plus debounce FSM producing a clean level and rise/fall pulses.
// Define JK_INPUT_ACTIVE_LOW_EN for board keys that read 0 when pressed.
module jk_input_conditioner #(
    parameter int N_CH            = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  clc,
    jk_input_conditioner_if.slave bus
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam bit SINGLE = (DEBOUNCE_CYCLES == 1);

    typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_e;

    logic [N_CH-1:0] in_n;
    logic [N_CH-1:0] s1_q;
    logic [N_CH-1:0] s2_q;

`ifdef JK_INPUT_ACTIVE_LOW_EN
    assign in_n = ~bus.btn_raw;
`else
    assign in_n = bus.btn_raw;
`endif

    always_ff @(posedge clk) begin
        if (clc) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= in_n;
            s2_q <= s1_q;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             rise_q, rise_d;
        logic             fall_q, fall_d;

        // Any sample matching the current level drops the count back to zero.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            unique case (state_q)
                STABLE_LO: begin
                    if (!s2_q[g]) begin
                        cnt_d = '0;
                    end else if (SINGLE) begin
                        state_d = STABLE_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_HI;
                        cnt_d   = CNT_ONE;
                    end
                end
                WAIT_HI: begin
                    if (!s2_q[g]) begin
                        state_d = STABLE_LO;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_HI;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STABLE_HI: begin
                    if (s2_q[g]) begin
                        cnt_d = '0;
                    end else if (SINGLE) begin
                        state_d = STABLE_LO;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        state_d = WAIT_LO;
                        cnt_d   = CNT_ONE;
                    end
                end
                WAIT_LO: begin
                    if (s2_q[g]) begin
                        state_d = STABLE_HI;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = STABLE_LO;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        always_ff @(posedge clk) begin
            if (clc) begin
                state_q <= STABLE_LO;
                cnt_q   <= '0;
                level_q <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                rise_q  <= rise_d;
                fall_q  <= fall_d;
            end
        end

        assign bus.btn_level[g] = level_q;
        assign bus.btn_rise[g]  = rise_q;
        assign bus.btn_fall[g]  = fall_q;
    end
endmodule
